// File: rtl/gc_dispenser.sv
// gc_dispenser: hands out loop indices gc + k*gd to N_CORE cores from a fork-loaded budget.
// Optional macro GC_DISPENSER_ROTATE_EN: rank from a rotating pointer instead of core 0.
module gc_dispenser #(
    parameter int N_CORE    = 5,
    parameter int GC_WIDTH  = 32,
    parameter int GD_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_fork_valid,
    input  logic [GC_WIDTH-1:0]             i_fork_gc,
    input  logic [GD_WIDTH-1:0]             i_fork_gd,
    input  logic [CNT_WIDTH-1:0]            i_fork_count,
    input  logic [N_CORE-1:0]               i_req_valid,
    output logic [N_CORE-1:0]               o_req_ready,
    output logic [N_CORE-1:0]               o_grant_valid,
    output logic [N_CORE-1:0][GC_WIDTH-1:0] o_grant_gc,
    output logic                            o_active,
    output logic                            o_exhausted,
    output logic [CNT_WIDTH-1:0]            o_remaining
);
    localparam int RW = $clog2(N_CORE + 1);
    localparam int CW = (RW > CNT_WIDTH) ? RW : CNT_WIDTH;
    localparam int XW = (GC_WIDTH > GD_WIDTH) ? GC_WIDTH : GD_WIDTH;
    localparam int PW = (N_CORE > 1) ? $clog2(N_CORE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [GC_WIDTH-1:0]             r_gc;
    logic [GD_WIDTH-1:0]             r_gd;
    logic [CNT_WIDTH-1:0]            r_remaining;
    logic [N_CORE-1:0]               r_grant_valid;
    logic [N_CORE-1:0][GC_WIDTH-1:0] r_grant_gc;

    logic [N_CORE-1:0][RW-1:0]       w_rank;
    logic [RW-1:0]                   w_nvalid;
    logic                            w_accept_en;
    logic [N_CORE-1:0]               w_ready;
    logic [CNT_WIDTH-1:0]            w_n;
    logic [XW-1:0]                   w_gd_x;
    logic [GC_WIDTH-1:0]             w_gd_ext;
    logic [N_CORE-1:0][GC_WIDTH-1:0] w_index;

`ifdef GC_DISPENSER_ROTATE_EN
    logic [PW-1:0]                   r_ptr;
    logic [PW-1:0]                   w_last;
    logic [PW-1:0]                   w_ptr_next;
`endif

    // Rank each valid request by how many valid requests precede it in priority order.
    always_comb begin
        int idx;
        w_rank   = '0;
        w_nvalid = '0;
`ifdef GC_DISPENSER_ROTATE_EN
        w_last   = '0;
`endif
        for (int k = 0; k < N_CORE; k++) begin
`ifdef GC_DISPENSER_ROTATE_EN
            idx = int'(r_ptr) + k;
            if (idx >= N_CORE) idx = idx - N_CORE;
            if (i_req_valid[idx] && (CW'(w_nvalid) + CW'(1) == CW'(r_remaining)))
                w_last = PW'(idx);
`else
            idx = k;
`endif
            w_rank[idx] = w_nvalid;
            if (i_req_valid[idx]) w_nvalid = w_nvalid + RW'(1);
        end
    end

    // A fork or reset in the same cycle suppresses every acceptance.
    always_comb begin
        w_accept_en = (r_state == S_ACTIVE) && !i_fork_valid && !i_reset;
        w_ready     = '0;
        w_n         = '0;
        for (int i = 0; i < N_CORE; i++)
            w_ready[i] = w_accept_en && i_req_valid[i] && (CW'(w_rank[i]) < CW'(r_remaining));
        if (w_accept_en)
            w_n = (CW'(w_nvalid) < CW'(r_remaining)) ? CNT_WIDTH'(w_nvalid) : r_remaining;
    end

    assign w_gd_x   = XW'($signed(r_gd));
    assign w_gd_ext = w_gd_x[GC_WIDTH-1:0];

    always_comb begin
        for (int i = 0; i < N_CORE; i++)
            w_index[i] = r_gc + GC_WIDTH'(w_rank[i]) * w_gd_ext;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (i_fork_valid)
            w_state_next = (i_fork_count != '0) ? S_ACTIVE : S_DONE;
        else if (w_accept_en && (w_n == r_remaining))
            w_state_next = S_DONE;
        o_active    = (r_state == S_ACTIVE);
        o_exhausted = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gc        <= '0;
            r_gd        <= '0;
            r_remaining <= '0;
        end else if (i_fork_valid) begin
            r_gc        <= i_fork_gc;
            r_gd        <= i_fork_gd;
            r_remaining <= i_fork_count;
        end else if (w_accept_en) begin
            r_gc        <= r_gc + GC_WIDTH'(w_n) * w_gd_ext;
            r_remaining <= r_remaining - w_n;
        end
    end

    // Grant values are only overwritten for accepted cores so idle lanes hold their last index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_grant_valid <= '0;
            r_grant_gc    <= '0;
        end else begin
            r_grant_valid <= w_ready;
            for (int i = 0; i < N_CORE; i++)
                if (w_ready[i]) r_grant_gc[i] <= w_index[i];
        end
    end

`ifdef GC_DISPENSER_ROTATE_EN
    assign w_ptr_next = (w_last == PW'(N_CORE - 1)) ? '0 : w_last + PW'(1);

    // The pointer only moves past the last winner when the budget truncates the request set.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_fork_valid)
            r_ptr <= '0;
        else if (w_accept_en && (CW'(r_remaining) < CW'(w_nvalid)))
            r_ptr <= w_ptr_next;
    end
`endif

    assign o_req_ready   = w_ready;
    assign o_grant_valid = r_grant_valid;
    assign o_grant_gc    = r_grant_gc;
    assign o_remaining   = r_remaining;
endmodule

// File: tb/tb_gc_dispenser.sv
// Self-checking bench for gc_dispenser: a behavioural model pushes expected grants into a
// scoreboard queue at drive time; each test pops them one cycle later and compares.
module tb_gc_dispenser;
    localparam int N = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               forkValid;
    logic [31:0]        forkGc;
    logic [31:0]        forkGd;
    logic [15:0]        forkCount;
    logic [N-1:0]       reqValid;
    logic [N-1:0]       reqReady;
    logic [N-1:0]       grantValid;
    logic [N-1:0][31:0] grantGc;
    logic               active;
    logic               exhausted;
    logic [15:0]        remaining;

    typedef struct {
        int          cyc;
        int          core;
        logic [31:0] gc;
    } sbEntry_t;

    sbEntry_t           sb[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 cycNum = 0;
    int                 mState = 0;
    logic [31:0]        mGc = '0;
    logic [31:0]        mGd = '0;
    logic [15:0]        mRem = '0;
    logic [N-1:0]       expReady;
    logic [N-1:0]       obsReady;
    logic [N-1:0]       expMask;
    logic [N-1:0][31:0] expGc = '0;

    gc_dispenser #(.N_CORE(N), .GC_WIDTH(32), .GD_WIDTH(32), .CNT_WIDTH(16)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_fork_valid (forkValid),
        .i_fork_gc    (forkGc),
        .i_fork_gd    (forkGd),
        .i_fork_count (forkCount),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .o_grant_valid(grantValid),
        .o_grant_gc   (grantGc),
        .o_active     (active),
        .o_exhausted  (exhausted),
        .o_remaining  (remaining)
    );

    always #5 clk = ~clk;

    // Drives one cycle, runs the reference model and pushes the grants it predicts.
    task automatic applyStimulus(input logic rst, input logic frk, input logic [31:0] gc,
                                 input logic [31:0] gd, input logic [15:0] cnt,
                                 input logic [N-1:0] req);
        int       n;
        sbEntry_t e;
        reset     = rst;
        forkValid = frk;
        forkGc    = gc;
        forkGd    = gd;
        forkCount = cnt;
        reqValid  = req;
        expReady  = '0;
        n         = 0;
        if (!rst && !frk && mState == 1) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && n < int'(mRem)) begin
                    expReady[i] = 1'b1;
                    e.cyc  = cycNum;
                    e.core = i;
                    e.gc   = mGc + 32'(n) * mGd;
                    sb.push_back(e);
                    n++;
                end
            end
        end
        #3 obsReady = reqReady;
        @(posedge clk);
        #1;
        if (rst) begin
            mState = 0; mGc = '0; mGd = '0; mRem = '0; expGc = '0;
            sb.delete();
        end else if (frk) begin
            mGc = gc; mGd = gd; mRem = cnt;
            mState = (cnt != 16'd0) ? 1 : 2;
        end else if (mState == 1) begin
            mGc  = mGc + 32'(n) * mGd;
            mRem = mRem - 16'(n);
            if (mRem == 16'd0) mState = 2;
        end
        cycNum++;
    endtask

    task automatic test_reset();
        sbEntry_t e;
        for (int s = 0; s < 3; s++) begin
            applyStimulus(s < 2, 1'b0, 32'd0, 32'd0, 16'd0, 5'b11111);
            expMask = '0;
            while (sb.size() > 0 && sb[0].cyc == cycNum - 1) begin
                e = sb.pop_front(); expMask[e.core] = 1'b1; expGc[e.core] = e.gc;
            end
            checks++;
            if (obsReady !== expReady) begin errors++; $display("[TB] FAIL reset_ready: got %b want %b", obsReady, expReady); end
            checks++;
            if (grantValid !== expMask) begin errors++; $display("[TB] FAIL reset_gvalid: got %b want %b", grantValid, expMask); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (grantGc[i] !== expGc[i]) begin errors++; $display("[TB] FAIL reset_ggc[%0d]: got %h want %h", i, grantGc[i], expGc[i]); end
            end
            checks++;
            if ({active, exhausted, remaining} !== {mState == 1, mState == 2, mRem}) begin
                errors++; $display("[TB] FAIL reset_status: got a=%b e=%b r=%0d want state=%0d r=%0d", active, exhausted, remaining, mState, mRem);
            end
        end
    endtask

    task automatic test_basic();
        sbEntry_t e;
        logic [N-1:0] reqs [4] = '{5'b11111, 5'b11111, 5'b11111, 5'b00000};
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b0, s == 0, 32'd100, 32'd3, 16'd20, reqs[s]);
            expMask = '0;
            while (sb.size() > 0 && sb[0].cyc == cycNum - 1) begin
                e = sb.pop_front(); expMask[e.core] = 1'b1; expGc[e.core] = e.gc;
            end
            checks++;
            if (obsReady !== expReady) begin errors++; $display("[TB] FAIL basic_ready: got %b want %b", obsReady, expReady); end
            checks++;
            if (grantValid !== expMask) begin errors++; $display("[TB] FAIL basic_gvalid: got %b want %b", grantValid, expMask); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (grantGc[i] !== expGc[i]) begin errors++; $display("[TB] FAIL basic_ggc[%0d]: got %0d want %0d", i, grantGc[i], expGc[i]); end
            end
            checks++;
            if ({active, exhausted, remaining} !== {mState == 1, mState == 2, mRem}) begin
                errors++; $display("[TB] FAIL basic_status: got a=%b e=%b r=%0d want state=%0d r=%0d", active, exhausted, remaining, mState, mRem);
            end
            if (s == 1) begin
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (grantGc[i] !== 32'(100 + 3 * i)) begin errors++; $display("[TB] FAIL basic_const_gc[%0d]: got %0d want %0d", i, grantGc[i], 100 + 3 * i); end
                end
                checks++;
                if (remaining !== 16'd15) begin errors++; $display("[TB] FAIL basic_rem15: got %0d want 15", remaining); end
            end
            if (s == 2) begin
                checks++;
                if (remaining !== 16'd10 || grantGc[0] !== 32'd115) begin
                    errors++; $display("[TB] FAIL basic_rem10: got r=%0d gc0=%0d want r=10 gc0=115", remaining, grantGc[0]);
                end
            end
        end
    endtask

    task automatic test_sparse();
        sbEntry_t e;
        logic [N-1:0] reqs [3] = '{5'b00000, 5'b10101, 5'b00000};
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, s == 0, 32'd0, 32'd1, 16'd10, reqs[s]);
            expMask = '0;
            while (sb.size() > 0 && sb[0].cyc == cycNum - 1) begin
                e = sb.pop_front(); expMask[e.core] = 1'b1; expGc[e.core] = e.gc;
            end
            checks++;
            if (obsReady !== expReady) begin errors++; $display("[TB] FAIL sparse_ready: got %b want %b", obsReady, expReady); end
            checks++;
            if (grantValid !== expMask) begin errors++; $display("[TB] FAIL sparse_gvalid: got %b want %b", grantValid, expMask); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (grantGc[i] !== expGc[i]) begin errors++; $display("[TB] FAIL sparse_ggc[%0d]: got %0d want %0d", i, grantGc[i], expGc[i]); end
            end
            checks++;
            if ({active, exhausted, remaining} !== {mState == 1, mState == 2, mRem}) begin
                errors++; $display("[TB] FAIL sparse_status: got a=%b e=%b r=%0d want state=%0d r=%0d", active, exhausted, remaining, mState, mRem);
            end
            if (s == 1) begin
                checks++;
                if (grantValid !== 5'b10101 || grantGc[2] !== 32'd1 || grantGc[4] !== 32'd2 || remaining !== 16'd7) begin
                    errors++; $display("[TB] FAIL sparse_const: got v=%b gc2=%0d gc4=%0d r=%0d want v=10101 gc2=1 gc4=2 r=7", grantValid, grantGc[2], grantGc[4], remaining);
                end
            end
        end
    endtask

    task automatic test_truncation();
        sbEntry_t e;
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, s == 0, 32'd200, 32'd5, 16'd2, 5'b11111);
            expMask = '0;
            while (sb.size() > 0 && sb[0].cyc == cycNum - 1) begin
                e = sb.pop_front(); expMask[e.core] = 1'b1; expGc[e.core] = e.gc;
            end
            checks++;
            if (obsReady !== expReady) begin errors++; $display("[TB] FAIL trunc_ready: got %b want %b", obsReady, expReady); end
            checks++;
            if (grantValid !== expMask) begin errors++; $display("[TB] FAIL trunc_gvalid: got %b want %b", grantValid, expMask); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (grantGc[i] !== expGc[i]) begin errors++; $display("[TB] FAIL trunc_ggc[%0d]: got %0d want %0d", i, grantGc[i], expGc[i]); end
            end
            checks++;
            if ({active, exhausted, remaining} !== {mState == 1, mState == 2, mRem}) begin
                errors++; $display("[TB] FAIL trunc_status: got a=%b e=%b r=%0d want state=%0d r=%0d", active, exhausted, remaining, mState, mRem);
            end
            if (s == 1) begin
                checks++;
                if (obsReady !== 5'b00011 || exhausted !== 1'b1 || active !== 1'b0 || grantGc[1] !== 32'd205) begin
                    errors++; $display("[TB] FAIL trunc_const: got rdy=%b e=%b a=%b gc1=%0d want rdy=00011 e=1 a=0 gc1=205", obsReady, exhausted, active, grantGc[1]);
                end
            end
        end
    endtask

    task automatic test_negative_stride();
        sbEntry_t e;
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b0, s == 0, 32'd1, 32'hFFFF_FFFE, 16'd3, 5'b11111);
            expMask = '0;
            while (sb.size() > 0 && sb[0].cyc == cycNum - 1) begin
                e = sb.pop_front(); expMask[e.core] = 1'b1; expGc[e.core] = e.gc;
            end
            checks++;
            if (obsReady !== expReady) begin errors++; $display("[TB] FAIL negstride_ready: got %b want %b", obsReady, expReady); end
            checks++;
            if (grantValid !== expMask) begin errors++; $display("[TB] FAIL negstride_gvalid: got %b want %b", grantValid, expMask); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (grantGc[i] !== expGc[i]) begin errors++; $display("[TB] FAIL negstride_ggc[%0d]: got %h want %h", i, grantGc[i], expGc[i]); end
            end
            checks++;
            if ({active, exhausted, remaining} !== {mState == 1, mState == 2, mRem}) begin
                errors++; $display("[TB] FAIL negstride_status: got a=%b e=%b r=%0d want state=%0d r=%0d", active, exhausted, remaining, mState, mRem);
            end
            if (s == 1) begin
                checks++;
                if (grantGc[0] !== 32'h1 || grantGc[1] !== 32'hFFFF_FFFF || grantGc[2] !== 32'hFFFF_FFFD) begin
                    errors++; $display("[TB] FAIL negstride_const: got %h %h %h want 00000001 ffffffff fffffffd", grantGc[0], grantGc[1], grantGc[2]);
                end
            end
        end
    endtask

    task automatic test_fork_collision();
        sbEntry_t e;
        logic         frks [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0]  cnts [4] = '{16'd9, 16'd0, 16'd0, 16'd0};
        logic [N-1:0] reqs [4] = '{5'b00000, 5'b00011, 5'b00011, 5'b00011};
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b0, frks[s], (s == 0) ? 32'd0 : 32'd50, 32'd1, cnts[s], reqs[s]);
            expMask = '0;
            while (sb.size() > 0 && sb[0].cyc == cycNum - 1) begin
                e = sb.pop_front(); expMask[e.core] = 1'b1; expGc[e.core] = e.gc;
            end
            checks++;
            if (obsReady !== expReady) begin errors++; $display("[TB] FAIL collide_ready: got %b want %b", obsReady, expReady); end
            checks++;
            if (grantValid !== expMask) begin errors++; $display("[TB] FAIL collide_gvalid: got %b want %b", grantValid, expMask); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (grantGc[i] !== expGc[i]) begin errors++; $display("[TB] FAIL collide_ggc[%0d]: got %0d want %0d", i, grantGc[i], expGc[i]); end
            end
            checks++;
            if ({active, exhausted, remaining} !== {mState == 1, mState == 2, mRem}) begin
                errors++; $display("[TB] FAIL collide_status: got a=%b e=%b r=%0d want state=%0d r=%0d", active, exhausted, remaining, mState, mRem);
            end
            if (s == 2) begin
                checks++;
                if (obsReady !== 5'b00000 || exhausted !== 1'b1 || grantValid !== 5'b00000) begin
                    errors++; $display("[TB] FAIL collide_const: got rdy=%b e=%b v=%b want rdy=00000 e=1 v=00000", obsReady, exhausted, grantValid);
                end
            end
        end
    endtask

    task automatic test_reset_mid_loop();
        sbEntry_t e;
        for (int s = 0; s < 4; s++) begin
            applyStimulus(s == 2, s == 0, 32'd10, 32'd1, 16'd100, 5'b11111);
            expMask = '0;
            while (sb.size() > 0 && sb[0].cyc == cycNum - 1) begin
                e = sb.pop_front(); expMask[e.core] = 1'b1; expGc[e.core] = e.gc;
            end
            checks++;
            if (obsReady !== expReady) begin errors++; $display("[TB] FAIL rstmid_ready: got %b want %b", obsReady, expReady); end
            checks++;
            if (grantValid !== expMask) begin errors++; $display("[TB] FAIL rstmid_gvalid: got %b want %b", grantValid, expMask); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (grantGc[i] !== expGc[i]) begin errors++; $display("[TB] FAIL rstmid_ggc[%0d]: got %0d want %0d", i, grantGc[i], expGc[i]); end
            end
            checks++;
            if ({active, exhausted, remaining} !== {mState == 1, mState == 2, mRem}) begin
                errors++; $display("[TB] FAIL rstmid_status: got a=%b e=%b r=%0d want state=%0d r=%0d", active, exhausted, remaining, mState, mRem);
            end
            if (s == 2) begin
                checks++;
                if (grantValid !== 5'b00000 || remaining !== 16'd0 || active !== 1'b0 || grantGc !== '0) begin
                    errors++; $display("[TB] FAIL rstmid_const: got v=%b r=%0d a=%b want all zero", grantValid, remaining, active);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; forkValid = 1'b0; forkGc = '0; forkGd = '0; forkCount = '0; reqValid = '0;
        test_reset();
        test_basic();
        test_sparse();
        test_truncation();
        test_negative_stride();
        test_fork_collision();
        test_reset_mid_loop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
